ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

Registered operand-select stage directly upstream of the execute-stage ALU/shift unit. Accepts decoded instructions with register-file read data. Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results. Selects immediate vs. register for operand B, and holds the result in a valid/ready pipeline register that drives `op_a`, `op_b` and `alu_ctrl` of the execute stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RADDR_W`, 5, register-address width

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: synchronous reset, active low
- `in_valid` in 1: decode has an instruction
- `in_ready` out 1: stage can accept this cycle
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in RADDR_W: source and destination register indices
- `in_rs1_data`, `in_rs2_data` in XLEN: register-file read data
- `in_imm` in XLEN: sign-extended immediate
- `in_use_imm` in 1: operand B = immediate
- `in_alu_ctrl` in 4: ALU/shift opcode (0101 SLL, 0110 SRL, 0111 SRA, others per ALU)
- `in_reg_write` in 1: instruction writes `rd`
- `exmem_reg_write` in 1, `exmem_rd` in RADDR_W, `exmem_result` in XLEN: EX/MEM forwarding source
- `memwb_reg_write` in 1, `memwb_rd` in RADDR_W, `memwb_result` in XLEN: MEM/WB forwarding source
- `flush` in 1: squash held and incoming instruction (branch redirect)
- `out_valid` out 1, `out_ready` in 1: handshake to execute
- `out_op_a`, `out_op_b` out XLEN: resolved operands
- `out_alu_ctrl` out 4, `out_rd` out RADDR_W, `out_reg_write` out 1: payload to execute

## Operation
- Single-entry pipeline register; state is EMPTY (`out_valid=0`) or FULL (`out_valid=1`).
- `in_ready = ~flush & (~out_valid | out_ready)`.
- Load when `in_valid & in_ready`. The register captures resolved operands and payload, and `out_valid` goes to 1.
- Drain when `out_valid & out_ready` with no load. `out_valid` goes to 0 and the payload holds its last value.
- Load and drain in the same cycle: the new entry replaces the old one. No bubble occurs and throughput is 1/cycle.
- `flush=1`: `out_valid` is 0 at the next edge and the incoming instruction is dropped. Flush overrides load and drain.
- Forwarding per source operand s (rs1 and rs2):
  - If `exmem_reg_write & exmem_rd==s & s!=0`, use `exmem_result`.
  - Otherwise, if `memwb_reg_write & memwb_rd==s & s!=0`, use `memwb_result`.
  - Otherwise, use `in_rsN_data`.
  - EX/MEM has priority over MEM/WB.
- `out_op_b` = `in_imm` when `in_use_imm`, else forwarded rs2. `out_op_a` = forwarded rs1.
- Register x0 is never forwarded; x0 reads pass through unchanged.
- Full XLEN values are passed through unmodified. Shift-amount masking is done downstream.
- Payload is held stable while `out_valid & ~out_ready`.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`.
- Forwarding and operand-select logic is combinational on inputs in the accept cycle. Forwarding sources are sampled only in that cycle.
- Reset (`rst_n=0` at an edge): `out_valid=0`, `out_op_a=0`, `out_op_b=0`, `out_alu_ctrl=0`, `out_rd=0`, `out_reg_write=0`.
- Reset mid-operation discards the held entry. `in_ready` is 1 in the first cycle after reset unless `flush=1`.
- Reset has priority over flush, and flush over load.

## Configuration
- `EX_OPERAND_FWD_EN` defined: forwarding muxes are present as in Operation.
- Not defined: operands are taken directly from `in_rs1_data`/`in_rs2_data`, or `in_imm` for operand B. The forwarding ports remain on the interface and are ignored. Hazards are then resolved by decode stalling.

## Structure
- Shared package `ex_pkg`:
  - `XLEN`, `RADDR_W`
  - `alu_ctrl_t` enum: `ALU_SLL=4'b0101`, `ALU_SRL=4'b0110`, `ALU_SRA=4'b0111`, and the remaining ALU codes
  - `ex_payload_t` struct: `op_a`, `op_b`, `alu_ctrl`, `rd`, `reg_write`
- One sub-module `fwd_mux`: combinational per-operand priority selector, instantiated twice. Used only when `EX_OPERAND_FWD_EN` is defined.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles → all outputs 0 and `in_ready=1` after release.
- Forwarding priority: rs1=x5 with `in_rs1_data=0x11`, `exmem_rd=5` with `exmem_result=0xAAAA0000`, and `memwb_rd=5` with `memwb_result=0x55` → `out_op_a=0xAAAA0000` next cycle. Same stimulus with `exmem_reg_write=0` → `out_op_a=0x55`.
- x0 guard: rs2=x0, `exmem_rd=0`, `exmem_result=0xFFFFFFFF`, `in_rs2_data=0`, `in_use_imm=0` → `out_op_b=0`.
- Immediate select: `in_use_imm=1`, `in_imm=0x0000001F`, `alu_ctrl=0111` → `out_op_b=0x1F` and `out_alu_ctrl=0111`, with no forwarding applied to operand B.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0` and payload stable. When `out_ready=1`, the held entry drains and the next entry loads in the same cycle with no bubble.
- Flush: FULL with `flush=1` and `in_valid=1` → `in_ready=0`, then `out_valid=0` next cycle and the input is dropped. Repeat with the macro undefined → forwarding inputs are ignored.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and widths for the execute operand stage
package ex_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_R10  = 4'b1010,
    ALU_R11  = 4'b1011,
    ALU_R12  = 4'b1100,
    ALU_R13  = 4'b1101,
    ALU_R14  = 4'b1110,
    ALU_R15  = 4'b1111
  } alu_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]    op_a;
    logic [XLEN-1:0]    op_b;
    alu_ctrl_t          alu_ctrl;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
  } ex_payload_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand forwarding priority selector
// Ports:
//   src_addr_i                 source register index
//   rf_data_i                  register-file read data
//   exmem_* / memwb_*          forwarding sources (EX/MEM wins)
//   data_o                     resolved operand
module fwd_mux
  import ex_pkg::*;
#(
  parameter int XLEN    = ex_pkg::XLEN,
  parameter int RADDR_W = ex_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] src_addr_i,
  input  logic [XLEN-1:0]    rf_data_i,
  input  logic               exmem_reg_write_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]    exmem_result_i,
  input  logic               memwb_reg_write_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]    memwb_result_i,
  output logic [XLEN-1:0]    data_o
);

  logic src_nz;
  logic hit_exmem;
  logic hit_memwb;

  // x0 is hardwired zero, so a producer naming rd=0 must never be forwarded.
  assign src_nz    = |src_addr_i;
  assign hit_exmem = exmem_reg_write_i && (exmem_rd_i == src_addr_i) && src_nz;
  assign hit_memwb = memwb_reg_write_i && (memwb_rd_i == src_addr_i) && src_nz;

  always_comb begin
    data_o = rf_data_i;
    if (hit_exmem) begin
      data_o = exmem_result_i;
    end else if (hit_memwb) begin
      data_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - registered operand select with forwarding ahead of execute
// Option macro: EX_OPERAND_FWD_EN (forwarding muxes present when defined).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_*                       decoded instruction + register-file data, valid/ready
//   exmem_*, memwb_*           forwarding sources
//   flush                      squash held and incoming instruction
//   out_*                      operands and payload to execute, valid/ready
// XLEN/RADDR_W must match ex_pkg since the payload register uses ex_payload_t.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = ex_pkg::XLEN,
  parameter int RADDR_W = ex_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs1_addr,
  input  logic [RADDR_W-1:0] in_rs2_addr,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_use_imm,
  input  logic [3:0]         in_alu_ctrl,
  input  logic               in_reg_write,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_op_a,
  output logic [XLEN-1:0]    out_op_b,
  output logic [3:0]         out_alu_ctrl,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_reg_write
);

  logic        valid_q;
  logic        valid_d;
  ex_payload_t payload_q;
  ex_payload_t payload_d;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic        load;

`ifdef EX_OPERAND_FWD_EN
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .src_addr_i        (in_rs1_addr),
    .rf_data_i         (in_rs1_data),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_result_i    (memwb_result),
    .data_o            (rs1_val)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .src_addr_i        (in_rs2_addr),
    .rf_data_i         (in_rs2_data),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_result_i    (memwb_result),
    .data_o            (rs2_val)
  );
`else
  // Decode stalls on hazards in this build, so the forwarding inputs are inert.
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{in_rs1_addr, in_rs2_addr, exmem_reg_write, exmem_rd,
                        exmem_result, memwb_reg_write, memwb_rd, memwb_result};
`endif

  // A full register may still accept when execute drains it in the same cycle.
  assign in_ready = ~flush & (~valid_q | out_ready);
  assign load     = in_valid & in_ready;

  always_comb begin
    payload_d           = payload_q;
    valid_d             = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d             = 1'b1;
      payload_d.op_a      = rs1_val;
      payload_d.op_b      = in_use_imm ? in_imm : rs2_val;
      payload_d.alu_ctrl  = alu_ctrl_t'(in_alu_ctrl);
      payload_d.rd        = in_rd_addr;
      payload_d.reg_write = in_reg_write;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_op_a      = payload_q.op_a;
  assign out_op_b      = payload_q.op_b;
  assign out_alu_ctrl  = payload_q.alu_ctrl;
  assign out_rd        = payload_q.rd;
  assign out_reg_write = payload_q.reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_ctrl;
  logic        in_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op_a, out_op_b;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rs1_addr     (in_rs1_addr),
    .in_rs2_addr     (in_rs2_addr),
    .in_rd_addr      (in_rd_addr),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .in_imm          (in_imm),
    .in_use_imm      (in_use_imm),
    .in_alu_ctrl     (in_alu_ctrl),
    .in_reg_write    (in_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_op_a        (out_op_a),
    .out_op_b        (out_op_b),
    .out_alu_ctrl    (out_alu_ctrl),
    .out_rd          (out_rd),
    .out_reg_write   (out_reg_write)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic use_imm,
                           input logic [3:0] alu, input logic [4:0] rd, input logic rw);
    in_rs1_addr  = rs1;  in_rs1_data = d1;
    in_rs2_addr  = rs2;  in_rs2_data = d2;
    in_imm       = imm;  in_use_imm  = use_imm;
    in_alu_ctrl  = alu;  in_rd_addr  = rd;  in_reg_write = rw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_instr(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset held for two edges
    step(); step();
    rst_n = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_op_a", out_op_a, 0);
    check("rst_op_b", out_op_b, 0);
    check("rst_alu", out_alu_ctrl, 0);
    check("rst_rd", out_rd, 0);
    check("rst_rw", out_reg_write, 0);
    check("rst_in_ready", in_ready, 1);

    // Forwarding priority: EX/MEM beats MEM/WB
    in_valid = 1'b1;
    set_instr(5'd5, 32'h11, 5'd6, 32'h22, 32'h0, 1'b0, 4'h0, 5'd7, 1'b1);
    set_fwd(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h55);
    step();
    check("prio_valid", out_valid, 1);
    check("prio_op_a", out_op_a, FWD ? 32'hAAAA0000 : 32'h11);
    check("prio_op_b", out_op_b, 32'h22);
    check("prio_rd", out_rd, 7);
    check("prio_rw", out_reg_write, 1);

    // EX/MEM not writing: MEM/WB used
    set_fwd(1'b0, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h55);
    step();
    check("memwb_op_a", out_op_a, FWD ? 32'h55 : 32'h11);

    // Mixed: rs1 from EX/MEM, rs2 from MEM/WB
    set_instr(5'd3, 32'h10, 5'd9, 32'h99, 32'h0, 1'b0, 4'h1, 5'd4, 1'b0);
    set_fwd(1'b1, 5'd3, 32'hBEEF, 1'b1, 5'd9, 32'hCAFE);
    step();
    check("mix_op_a", out_op_a, FWD ? 32'hBEEF : 32'h10);
    check("mix_op_b", out_op_b, FWD ? 32'hCAFE : 32'h99);
    check("mix_alu", out_alu_ctrl, 4'h1);
    check("mix_rw", out_reg_write, 0);

    // x0 is never forwarded
    set_instr(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd1, 1'b1);
    set_fwd(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h1234);
    step();
    check("x0_op_a", out_op_a, 32'h0);
    check("x0_op_b", out_op_b, 32'h0);

    // Immediate select ignores forwarding on operand B
    set_instr(5'd2, 32'h20, 5'd5, 32'h33, 32'h0000001F, 1'b1, 4'b0111, 5'd12, 1'b1);
    set_fwd(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    step();
    check("imm_op_b", out_op_b, 32'h1F);
    check("imm_alu", out_alu_ctrl, 4'b0111);
    check("imm_op_a", out_op_a, 32'h20);
    check("imm_rd", out_rd, 12);

    // Backpressure: entry held stable for 3 cycles
    out_ready = 1'b0;
    set_instr(5'd1, 32'hB1, 5'd2, 32'hB2, 32'h0, 1'b0, 4'h1, 5'd2, 1'b0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_op_b", out_op_b, 32'h1F);
      check("bp_alu", out_alu_ctrl, 4'b0111);
      check("bp_in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("nobubble_valid", out_valid, 1);
    check("nobubble_op_a", out_op_a, 32'hB1);
    check("nobubble_op_b", out_op_b, 32'hB2);
    check("nobubble_rw", out_reg_write, 0);

    // Drain with no load: valid drops, payload holds
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);
    check("drain_hold_a", out_op_a, 32'hB1);
    check("drain_ready", in_ready, 1);

    // Flush while full drops held and incoming
    in_valid = 1'b1;
    set_instr(5'd1, 32'hC1, 5'd2, 32'hC2, 32'h0, 1'b0, 4'h2, 5'd3, 1'b1);
    step();
    check("pre_flush_valid", out_valid, 1);
    out_ready = 1'b0;
    flush = 1'b1;
    set_instr(5'd1, 32'hD1, 5'd2, 32'hD2, 32'h0, 1'b0, 4'h3, 5'd4, 1'b1);
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    check("flush_valid", out_valid, 0);
    check("flush_dropped", out_op_a, 32'hC1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_flush_valid", out_valid, 0);

    // Reset mid-operation with flush also asserted
    in_valid = 1'b1;
    set_instr(5'd1, 32'hE1, 5'd2, 32'hE2, 32'h0, 1'b0, 4'h4, 5'd6, 1'b1);
    step();
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_op_a", out_op_a, 0);
    check("mid_rst_rd", out_rd, 0);
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
